mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// port index constants used by the arbiter and its grant picker.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Grant decision for the two requesters. A tie goes to whichever port was not
// granted last; tying last_grant to PORT_CPU turns this into fixed DMA priority.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_grant,
    output logic grant
);

    logic tie;

    assign tie = cpu_req & dma_req;

    always_comb begin
        grant = PORT_CPU;
        if (tie) begin
            grant = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
        end else if (dma_req) begin
            grant = PORT_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU/DMA) single-memory arbiter with wait-state timeout.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise DMA has fixed priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q;
    state_t              state_d;

    logic                pick_grant;
    logic                last_grant;
    logic                grant_q;

    logic                cmd_we_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [DATA_W-1:0]   cmd_wdata_q;

    logic [CNT_W-1:0]    wait_cnt_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dma_rdata_q;
    logic                timeout_err_q;

    logic                in_access;
    logic                access_ok;
    logic                access_expired;

    assign in_access      = (state_q == ACCESS);
    assign access_ok      = in_access & mem_ready;
    // mem_ready on the final allowed cycle still wins over the timeout
    assign access_expired = in_access & ~mem_ready & (wait_cnt_q == WAIT_LAST);

    mem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_grant (last_grant),
        .grant      (pick_grant)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= PORT_CPU;
        end else if (state_q == ARB) begin
            last_grant_q <= pick_grant;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = PORT_CPU;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (access_ok || access_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The command is frozen in ARB so requester changes during the access are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= PORT_CPU;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else if (state_q == ARB) begin
            grant_q <= pick_grant;
            if (pick_grant == PORT_DMA) begin
                cmd_we_q    <= dma_we;
                cmd_addr_q  <= dma_addr;
                cmd_wdata_q <= dma_wdata;
            end else begin
                cmd_we_q    <= cpu_we;
                cmd_addr_q  <= cpu_addr;
                cmd_wdata_q <= cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ARB) begin
            wait_cnt_q <= '0;
        end else if (in_access && !mem_ready) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // An expired access returns all-ones so the requester sees an obvious poison value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else if (access_ok) begin
            if (grant_q == PORT_DMA) begin
                dma_rdata_q <= mem_rdata;
            end else begin
                cpu_rdata_q <= mem_rdata;
            end
        end else if (access_expired) begin
            timeout_err_q <= 1'b1;
            if (grant_q == PORT_DMA) begin
                dma_rdata_q <= '1;
            end else begin
                cpu_rdata_q <= '1;
            end
        end
    end

    assign mem_read    = in_access & ~cmd_we_q;
    assign mem_write   = in_access &  cmd_we_q;
    assign mem_addr    = in_access ? cmd_addr_q  : '0;
    assign mem_wdata   = in_access ? cmd_wdata_q : '0;

    assign cpu_ready   = (state_q == DONE) && (grant_q == PORT_CPU);
    assign dma_ready   = (state_q == DONE) && (grant_q == PORT_DMA);
    assign cpu_rdata   = cpu_rdata_q;
    assign dma_rdata   = dma_rdata_q;
    assign timeout_err = timeout_err_q;

endmodule
